// File: rtl/spi_mem_frontend.sv
// SPI slave front end for the dual-address memory: turns MOSI frames into
// single-cycle write/read strobes and shifts read data back out on MISO.
module spi_mem_frontend #(
    parameter int MEM_WIDTH = 16,
    parameter int ADDR_SIZE = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ss_n,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 miso_oe,
    output logic [MEM_WIDTH-1:0] mem_din,
    output logic [ADDR_SIZE-1:0] mem_addr_wr,
    output logic [ADDR_SIZE-1:0] mem_addr_rd,
    output logic                 mem_wr_en,
    output logic                 mem_rd_en,
    output logic                 mem_blk_select,
    input  logic [MEM_WIDTH-1:0] mem_dout,
    output logic                 busy
);

    // Frame bit index of the last address bit, last write-data bit and the
    // edge that retires the final read bit.
    localparam int K_ADDR_LAST  = ADDR_SIZE + 1;
    localparam int K_DATA_LAST  = ADDR_SIZE + MEM_WIDTH + 1;
    localparam int K_SHIFT_LAST = ADDR_SIZE + MEM_WIDTH + 3;
    localparam int CNT_W        = $clog2(K_SHIFT_LAST + 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_OPC, ST_ADDR, ST_WDATA, ST_WSTROBE,
        ST_RSTROBE, ST_RLOAD, ST_RSHIFT, ST_DRAIN
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [CNT_W-1:0]       r_k;
    logic [1:0]             r_op;
    logic [ADDR_SIZE-1:0]   r_addr_sr;
    logic [MEM_WIDTH-1:0]   r_data_sr;
    logic [MEM_WIDTH-1:0]   r_rd_sr;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // ss_n high in any active state aborts the frame before anything else.
    always_comb begin
        w_next = r_state;
        if (r_state != ST_IDLE && ss_n) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (!ss_n) w_next = ST_OPC;
                ST_OPC:     w_next = r_op[1] ? ST_DRAIN : ST_ADDR;
                ST_ADDR:    if (r_k == CNT_W'(K_ADDR_LAST))
                                w_next = r_op[0] ? ST_RSTROBE : ST_WDATA;
                ST_WDATA:   if (r_k == CNT_W'(K_DATA_LAST)) w_next = ST_WSTROBE;
                ST_WSTROBE: w_next = ST_DRAIN;
                ST_RSTROBE: w_next = ST_RLOAD;
                ST_RLOAD:   w_next = ST_RSHIFT;
                ST_RSHIFT:  if (r_k == CNT_W'(K_SHIFT_LAST)) w_next = ST_DRAIN;
                ST_DRAIN:   w_next = ST_DRAIN;
                default:    w_next = ST_IDLE;
            endcase
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values, matching the hardware it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k         <= '0;
            r_op        <= '0;
            r_addr_sr   <= '0;
            r_data_sr   <= '0;
            r_rd_sr     <= '0;
            mem_din     <= '0;
            mem_addr_wr <= '0;
            mem_addr_rd <= '0;
        end else begin
            r_k <= (w_next == ST_IDLE || w_next == ST_DRAIN) ? '0 : r_k + 1'b1;
            case (r_state)
                ST_IDLE: if (!ss_n) r_op[1] <= mosi;
                ST_OPC:  if (!ss_n) r_op[0] <= mosi;
                ST_ADDR: if (!ss_n) begin
                    r_addr_sr <= {r_addr_sr[ADDR_SIZE-2:0], mosi};
                    if (w_next == ST_RSTROBE)
                        mem_addr_rd <= {r_addr_sr[ADDR_SIZE-2:0], mosi};
                end
                ST_WDATA: if (!ss_n) begin
                    r_data_sr <= {r_data_sr[MEM_WIDTH-2:0], mosi};
                    if (w_next == ST_WSTROBE) begin
                        mem_din     <= {r_data_sr[MEM_WIDTH-2:0], mosi};
                        mem_addr_wr <= r_addr_sr;
                    end
                end
                ST_RLOAD:  if (w_next == ST_RSHIFT) r_rd_sr <= mem_dout;
                ST_RSHIFT: r_rd_sr <= {r_rd_sr[MEM_WIDTH-2:0], 1'b0};
                default: ;
            endcase
        end
    end

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        mem_wr_en      = 1'b0;
        mem_rd_en      = 1'b0;
        miso_oe        = 1'b0;
        miso           = 1'b0;
        busy           = (r_state != ST_IDLE);
        if (r_state == ST_WSTROBE) mem_wr_en = 1'b1;
        if (r_state == ST_RSTROBE) mem_rd_en = 1'b1;
        if (r_state == ST_RSHIFT) begin
            miso_oe = 1'b1;
            miso    = r_rd_sr[MEM_WIDTH-1];
        end
        mem_blk_select = mem_wr_en | mem_rd_en;
    end

endmodule
